// File: rtl/ysyx_rf_scoreboard_pkg.sv
// Shared definitions for the register-file scoreboard.
//   sb_state_t       : scoreboard control state (RUN / FLUSH)
//   NR_REG_DEF       : default number of tracked architectural registers
//   MAX_INFLIGHT_DEF : default limit on outstanding register writes
//   reg_idx_t        : 4-bit architectural register index (RV32E)
package ysyx_rf_scoreboard_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } sb_state_t;

  localparam int unsigned NR_REG_DEF       = 16;
  localparam int unsigned MAX_INFLIGHT_DEF = 4;
  localparam int unsigned REG_IDX_W        = 4;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/ysyx_sat_cnt.sv
// Per-register pending-write counter: saturating up/down with synchronous clear.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   clr  : synchronous clear (highest priority after reset)
//   inc  : count up, held at all-ones
//   dec  : count down, held at zero
//   cnt  : current count
// inc and dec together leave the count unchanged.
module ysyx_sat_cnt #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_rf_scoreboard.sv
// Register-file scoreboard: tracks outstanding writes per architectural register,
// stalls issue on unresolved source dependencies and on write-resource limits.
//   clk, rst                 : clock, asynchronous active-low reset
//   iss_valid / iss_ready    : issue handshake from decode
//   iss_wen, iss_rd          : offered instruction writes iss_rd
//   iss_use_rs1/2, iss_rs1/2 : source usage and indices
//   fwd_valid, fwd_rd        : execute-stage result available for bypass
//   cmt_valid, cmt_rd        : write-back retires a write to cmt_rd
//   flush                    : squash all outstanding writes
//   rf_table                 : per-register "write pending" bitmap (bit 0 always 0)
//   hazard                   : offered instruction blocked by a source dependency
//   inflight                 : total outstanding writes
//   err                      : sticky, commit seen for a register with nothing pending
module ysyx_rf_scoreboard
  import ysyx_rf_scoreboard_pkg::*;
#(
  parameter int unsigned NR_REG       = NR_REG_DEF,
  parameter int unsigned CNT_W        = 2,
  parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic              iss_wen,
  input  logic [3:0]        iss_rd,
  input  logic              iss_use_rs1,
  input  logic              iss_use_rs2,
  input  logic [3:0]        iss_rs1,
  input  logic [3:0]        iss_rs2,
  input  logic              fwd_valid,
  input  logic [3:0]        fwd_rd,
  input  logic              cmt_valid,
  input  logic [3:0]        cmt_rd,
  input  logic              flush,
  output logic [NR_REG-1:0] rf_table,
  output logic              hazard,
  output logic [2:0]        inflight,
  output logic              err
);

  sb_state_t        state;
  logic [CNT_W-1:0] cnt [NR_REG];
  logic [NR_REG-1:1] inc_v;
  logic [NR_REG-1:1] dec_v;
  logic             wr_blk;
  logic             take;
  logic             iss_fire;
  logic             cmt_live;
  logic             cmt_dec;
  logic             cmt_bad;

  // x0 is hard-wired and never tracked.
  assign cnt[0] = '0;

  for (genvar i = 1; i < NR_REG; i++) begin : g_cnt
    ysyx_sat_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .inc (inc_v[i]),
      .dec (dec_v[i]),
      .cnt (cnt[i])
    );
  end

  always_comb begin
    rf_table = '0;
    for (int unsigned i = 0; i < NR_REG; i++) begin
      rf_table[i] = (cnt[i] != '0);
    end
  end

  // A pending source is not a hazard if execute is bypassing that very register.
  assign hazard = iss_valid &&
                  ((iss_use_rs1 && rf_table[iss_rs1] && !(fwd_valid && (fwd_rd == iss_rs1))) ||
                   (iss_use_rs2 && rf_table[iss_rs2] && !(fwd_valid && (fwd_rd == iss_rs2))));

  assign wr_blk    = iss_wen && (iss_rd != '0) &&
                     ((cnt[iss_rd] == '1) || (inflight == 3'(MAX_INFLIGHT)));
  assign iss_ready = (state == RUN) && !hazard && !wr_blk;

  // The cycle that raises flush discards any concurrent issue or commit.
  assign take     = (state == RUN) && !flush;
  assign iss_fire = take && iss_valid && iss_ready && iss_wen && (iss_rd != '0);
  assign cmt_live = take && cmt_valid && (cmt_rd != '0);
  assign cmt_dec  = cmt_live && (cnt[cmt_rd] != '0);
  assign cmt_bad  = cmt_live && (cnt[cmt_rd] == '0);

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    if (iss_fire) inc_v[iss_rd] = 1'b1;
    if (cmt_dec)  dec_v[cmt_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      inflight <= '0;
      err      <= 1'b0;
    end else begin
      state <= flush ? FLUSH : RUN;
      if (flush) begin
        inflight <= '0;
      end else if (iss_fire && !cmt_dec) begin
        inflight <= inflight + 1'b1;
      end else if (cmt_dec && !iss_fire) begin
        inflight <= inflight - 1'b1;
      end
      if (cmt_bad) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ysyx_rf_scoreboard.md
YSYX_RF_SCOREBOARD -- requirements
Module: ysyx_rf_scoreboard

Interface
REQ-001 Parameters SHALL be: NR_REG, default 16, number of tracked architectural registers (RV32E x0..x15); CNT_W, default 2, per-register pending-counter width; MAX_INFLIGHT, default 4, limit on total outstanding register writes.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 iss_valid  input  1  decode stage offers an instruction for issue.
REQ-005 iss_ready  output  1  scoreboard accepts the offered instruction this cycle.
REQ-006 iss_wen / iss_rd  input  1 / 4  offered instruction writes register iss_rd.
REQ-007 iss_use_rs1, iss_use_rs2 / iss_rs1, iss_rs2  input  1 each / 4 each  source-use flags and source indices.
REQ-008 fwd_valid / fwd_rd  input  1 / 4  execute stage has a forwardable result for fwd_rd this cycle.
REQ-009 cmt_valid / cmt_rd  input  1 / 4  write-back retires one register write to cmt_rd.
REQ-010 flush  input  1  speculation squash.
REQ-011 rf_table  output  16  bit i is 1 iff the pending count of register i is nonzero.
REQ-012 hazard  output  1  offered instruction is blocked by a source dependency.
REQ-013 inflight  output  3  total outstanding writes, 0..MAX_INFLIGHT.
REQ-014 err  output  1  sticky; set by a commit to a register whose count is zero.

Function
REQ-015 Each register 1..15 SHALL have a CNT_W-bit saturating pending counter; register 0 SHALL never be tracked, and rf_table[0] SHALL always be 0.
REQ-016 hazard SHALL be combinational: iss_valid & ((iss_use_rs1 & rf_table[iss_rs1] & !(fwd_valid & fwd_rd==iss_rs1)) | the same term for rs2).
REQ-017 iss_ready SHALL be state==RUN & !hazard & !(iss_wen & iss_rd!=0 & (cnt[iss_rd]==all-ones | inflight==MAX_INFLIGHT)).
REQ-018 An issue fire (iss_valid & iss_ready & iss_wen & iss_rd!=0) SHALL increment cnt[iss_rd] and inflight on the next edge.
REQ-019 A commit (cmt_valid & cmt_rd!=0 & cnt[cmt_rd]!=0) in RUN SHALL decrement cnt[cmt_rd] and inflight on the next edge.
REQ-020 A commit with cmt_valid & cmt_rd!=0 & cnt[cmt_rd]==0 SHALL change no counter and SHALL set err.
REQ-021 An issue fire and a commit to the same register in one cycle SHALL leave that counter and inflight unchanged.
REQ-022 An issue fire and a commit to different registers in one cycle SHALL apply both, leaving inflight unchanged.
REQ-023 FSM states SHALL be RUN and FLUSH.
REQ-024 RUN SHALL go to FLUSH when flush=1; FLUSH SHALL return to RUN after exactly one cycle unless flush is still 1.
REQ-025 On the edge entering FLUSH, all counters and inflight SHALL clear to 0; an issue or commit in the flush cycle SHALL be discarded.
REQ-026 In FLUSH, iss_ready SHALL be 0, and commits SHALL be ignored without setting err.
REQ-027 Latency SHALL be as follows: rf_table reflects an issue one cycle after the fire; forwarding removes a hazard in the same cycle.

Reset
REQ-028 While rst=0, all counters, inflight and err SHALL be 0 and state SHALL be RUN; rf_table therefore reads 0, and iss_ready follows REQ-017.
REQ-029 Reset asserted mid-operation SHALL clear state immediately, with no clock edge required.

Structure
REQ-030 A shared package SHALL hold the RUN/FLUSH state enum, the NR_REG and MAX_INFLIGHT defaults, and the 4-bit register-index typedef.
REQ-031 One sub-module, ysyx_sat_cnt (per-register saturating up/down counter with clear), SHALL be instantiated NR_REG-1 times.

Verification
REQ-032 Issue x5 write, then offer a reader of x5 with fwd_valid=0 -> hazard=1, iss_ready=0; then assert fwd_valid=1, fwd_rd=5 -> hazard=0 in the same cycle.
REQ-033 Issue three writes to x3 -> cnt=3; a fourth offer -> iss_ready=0; one commit x3 -> iss_ready=1 on the next cycle.
REQ-034 Issue four writes to x1..x4, then offer a write to x6 -> iss_ready=0 (inflight=4); commit x2 -> inflight=3 and rf_table=0x001A.
REQ-035 Issue x7 and commit x7 in the same cycle with cnt[7]=1 -> cnt[7] stays 1 and inflight is unchanged.
REQ-036 Pulse flush with rf_table=0x00F0 -> next cycle rf_table=0 and iss_ready=0; the following cycle iss_ready=1; a later commit x4 -> err=1.
REQ-037 Drop rst to 0 mid-issue with rf_table=0x0002 -> rf_table=0 and err=0 with no clock edge.
